// File: rtl/pipeline_mem_pkg.sv
// Shared exception codes and the store-buffer entry layout for the MEM stage.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pipeline_mem_pkg;
   localparam logic [2:0] EXC_NONE      = 3'd0;
   localparam logic [2:0] EXC_SB_FULL   = 3'd5;
   localparam logic [2:0] EXC_SB_HAZARD = 3'd6;

   // Widest word address supported; narrower ADDR_W builds zero-extend into it.
   localparam int SB_WADDR_W = 30;

   typedef struct packed {
      logic [SB_WADDR_W-1:0] waddr;
      logic [31:0]           data;
      logic [3:0]            be;
   } sb_entry_t;
endpackage

// File: rtl/store_buffer.sv
// Posted-store FIFO with per-entry valid bits and a parallel address-compare/merge port.
// Latency: a pushed entry is visible at the head and to the compare one cycle after the push edge.
// Backpressure: push must be gated by ~full and pop by ~empty; PIPELINE_MEM_SB_FWD_EN selects byte merge over hit.
module store_buffer
   import pipeline_mem_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  sb_entry_t             push_entry,
   input  logic                  pop,
   output sb_entry_t             head,
   output logic [CW-1:0]         count,
   output logic                  empty,
   output logic                  full,
   input  logic [SB_WADDR_W-1:0] cmp_waddr,
   input  logic [31:0]           base_data,
   output logic [31:0]           merged,
   output logic                  hit
);
   sb_entry_t        mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    head_ptr;
   logic [PW-1:0]    tail_ptr;
   logic [PW-1:0]    idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         vld      <= '0;
      end else begin
         if (push) begin
            tail_ptr      <= tail_ptr + PW'(1);
            vld[tail_ptr] <= 1'b1;
         end
         if (pop) begin
            head_ptr      <= head_ptr + PW'(1);
            vld[head_ptr] <= 1'b0;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail_ptr] <= push_entry;
   end

   assign head  = mem[head_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Walk oldest to youngest so a younger matching byte overwrites an older one.
   always_comb begin
      merged = base_data;
      hit    = 1'b0;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_ptr + PW'(i);
         if (vld[idx] && (mem[idx].waddr == cmp_waddr)) begin
`ifdef PIPELINE_MEM_SB_FWD_EN
            for (int b = 0; b < 4; b++) begin
               if (mem[idx].be[b]) merged[8*b +: 8] = mem[idx].data[8*b +: 8];
            end
`else
            hit = 1'b1;
`endif
         end
      end
   end
endmodule

// File: rtl/pipeline_mem_sb.sv
// MEM stage with posted store buffer; loads merge pending stores when PIPELINE_MEM_SB_FWD_EN is defined, else flag a hazard.
// Latency: loads and exceptions are combinational; stores post in one cycle and drain one per cycle.
// Backpressure: mem_wready stalls the drain only; a store into a full buffer is dropped with EXC_SB_FULL.
module pipeline_mem_sb
   import pipeline_mem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int SB_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               rt_value,
   input  logic [ADDR_W-1:0]         rd_value,
   input  logic [3:0]                wbyte_enable,
   input  logic                      memread_enable,
   input  logic                      memwrite_enable,
   input  logic                      alu_memop_disable,
   input  logic                      has_final_exception,
   output logic [31:0]               out_value,
   output logic [2:0]                exception,
   output logic                      mem_wvalid,
   input  logic                      mem_wready,
   output logic [ADDR_W-3:0]         mem_waddr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_wbe,
   output logic [ADDR_W-3:0]         mem_raddr,
   input  logic [31:0]               mem_rdata,
   output logic                      sb_empty,
   output logic [$clog2(SB_DEPTH):0] sb_count
);
   logic      ld;
   logic      st;
   logic      full;
   logic      hit;
   sb_entry_t push_entry;
   sb_entry_t head;
   logic      unused_addr_lsb;

   assign ld = memread_enable & ~alu_memop_disable;
   assign st = memwrite_enable & ~alu_memop_disable & ~has_final_exception;

   assign push_entry = '{waddr: SB_WADDR_W'(rd_value[ADDR_W-1:2]), data: rt_value, be: wbyte_enable};
   assign unused_addr_lsb = ^rd_value[1:0];

   store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
      .clk        (clk),
      .rst        (rst),
      .push       (st & ~full),
      .push_entry (push_entry),
      .pop        (mem_wvalid & mem_wready),
      .head       (head),
      .count      (sb_count),
      .empty      (sb_empty),
      .full       (full),
      .cmp_waddr  (SB_WADDR_W'(rd_value[ADDR_W-1:2])),
      .base_data  (mem_rdata),
      .merged     (out_value),
      .hit        (hit)
   );

   assign mem_wvalid = ~sb_empty;
   assign mem_waddr  = head.waddr[ADDR_W-3:0];
   assign mem_wdata  = head.data;
   assign mem_wbe    = head.be;
   assign mem_raddr  = rd_value[ADDR_W-1:2];

   // A store wins over a simultaneous load, so only a lone load can raise a hazard.
   always_comb begin
      exception = EXC_NONE;
      if (st) begin
         if (full) exception = EXC_SB_FULL;
      end else if (ld && hit) begin
         exception = EXC_SB_HAZARD;
      end
   end
endmodule

// File: tb/tb_pipeline_mem_sb.sv
// Randomized scoreboard bench for pipeline_mem_sb against a queue-based reference model.
module tb_pipeline_mem_sb;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] rt_value = '0;
   logic [31:0] rd_value = '0;
   logic [3:0]  wbyte_enable = '0;
   logic        memread_enable = 1'b0;
   logic        memwrite_enable = 1'b0;
   logic        alu_memop_disable = 1'b0;
   logic        has_final_exception = 1'b0;
   logic [31:0] out_value;
   logic [2:0]  exception;
   logic        mem_wvalid;
   logic        mem_wready = 1'b0;
   logic [29:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wbe;
   logic [29:0] mem_raddr;
   logic [31:0] mem_rdata = '0;
   logic        sb_empty;
   logic [2:0]  sb_count;

   typedef struct {
      logic [29:0] w;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;

   ent_t model_q[$];
   ent_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   pipeline_mem_sb #(.ADDR_W(32), .SB_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rt_value(rt_value), .rd_value(rd_value),
      .wbyte_enable(wbyte_enable), .memread_enable(memread_enable),
      .memwrite_enable(memwrite_enable), .alu_memop_disable(alu_memop_disable),
      .has_final_exception(has_final_exception), .out_value(out_value),
      .exception(exception), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .sb_empty(sb_empty),
      .sb_count(sb_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest pending store with that byte enabled supplies the byte.
   function automatic logic [31:0] load_model(input logic [29:0] w, input logic [31:0] rdata);
      logic [31:0] r;
      r = rdata;
`ifdef PIPELINE_MEM_SB_FWD_EN
      for (int b = 0; b < 4; b++) begin
         for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].w == w && model_q[i].be[b]) begin
               r[8*b +: 8] = model_q[i].d[8*b +: 8];
               break;
            end
         end
      end
`endif
      return r;
   endfunction

   function automatic bit addr_pending(input logic [29:0] w);
      foreach (model_q[i]) if (model_q[i].w == w) return 1'b1;
      return 1'b0;
   endfunction

   // One pipeline cycle: drive, check combinational outputs, advance the model, step the clock.
   task automatic cycle(input bit st_r, input bit ld_r, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input bit rdy,
                        input bit dis, input bit hfe, input logic [31:0] rdata);
      bit   ld;
      bit   st;
      bit   full;
      logic [2:0] exp_exc;
      ent_t e;
      memwrite_enable     = st_r;
      memread_enable      = ld_r;
      rd_value            = addr;
      rt_value            = data;
      wbyte_enable        = be;
      mem_wready          = rdy;
      alu_memop_disable   = dis;
      has_final_exception = hfe;
      mem_rdata           = rdata;
      #2;
      ld   = ld_r && !dis;
      st   = st_r && !dis && !hfe;
      full = (model_q.size() == DEPTH);
      chk("sb_count", {29'd0, sb_count}, model_q.size());
      chk("sb_empty", {31'd0, sb_empty}, {31'd0, model_q.size() == 0});
      chk("mem_wvalid", {31'd0, mem_wvalid}, {31'd0, model_q.size() != 0});
      chk("mem_raddr", {2'd0, mem_raddr}, {2'd0, addr[31:2]});
      if (st) exp_exc = full ? 3'd5 : 3'd0;
`ifdef PIPELINE_MEM_SB_FWD_EN
      else exp_exc = 3'd0;
`else
      else exp_exc = (ld && addr_pending(addr[31:2])) ? 3'd6 : 3'd0;
`endif
      chk("exception", {29'd0, exception}, {29'd0, exp_exc});
      if (ld && !st) chk("out_value", out_value, load_model(addr[31:2], rdata));
      if (model_q.size() > 0 && rdy) model_q.delete(0);
      if (st && !full) begin
         e.w = addr[31:2];
         e.d = data;
         e.be = be;
         model_q.push_back(e);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rdy);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdy, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input bit rdy);
      cycle(1'b1, 1'b0, a, d, be, rdy, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && model_q.size() != 0; n++) idle(1'b1);
      chk("drain_done", model_q.size(), 0);
   endtask

   // Write-port monitor: each accepted handshake must match the oldest expected store.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (rst && mem_wvalid && mem_wready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL drain_unexpected: got waddr %h, expected no write at %0t", mem_waddr, $time);
            end else begin
               e = exp_q.pop_front();
               chk("drain_waddr", {2'd0, mem_waddr}, {2'd0, e.w});
               chk("drain_wdata", mem_wdata, e.d);
               chk("drain_wbe", {28'd0, mem_wbe}, {28'd0, e.be});
            end
         end
      end
   end

   initial begin
      int r;
      #3;
      chk("rst_sb_count", {29'd0, sb_count}, 32'd0);
      chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
      chk("rst_mem_wvalid", {31'd0, mem_wvalid}, 32'd0);
      chk("rst_exception", {29'd0, exception}, 32'd0);
      #9 rst = 1'b1;
      @(posedge clk);
      #1;

      store(32'h10, 32'hAABBCCDD, 4'hF, 1'b0);
      chk("single_count", {29'd0, sb_count}, 32'd1);
      chk("single_waddr", {2'd0, mem_waddr}, 32'h4);
      chk("single_wdata", mem_wdata, 32'hAABBCCDD);
      idle(1'b1);
      chk("single_empty", {31'd0, sb_empty}, 32'd1);

      for (int k = 0; k < 4; k++) store(32'h100 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF, 1'b0);
      store(32'h180, 32'hDEADBEEF, 4'hF, 1'b0);
      chk("full_count", {29'd0, sb_count}, 32'd4);
      cycle(1'b1, 1'b0, 32'h184, 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0);
      store(32'h188, 32'h87654321, 4'hF, 1'b1);
      chk("full_drain_count", {29'd0, sb_count}, 32'd3);
      drain();

      store(32'h20, 32'h11223344, 4'b0011, 1'b0);
      cycle(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hAAAAAAAA);
      store(32'h20, 32'h00000055, 4'b0001, 1'b0);
      cycle(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'hAAAAAAAA);
      cycle(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h5A5A5A5A);
      cycle(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h13572468);
      drain();

      for (int k = 0; k < 3; k++) store(32'h300 + 32'(4 * k), 32'hFACE0000 + 32'(k), 4'hF, 1'b0);
      mem_wready = 1'b1;
      memwrite_enable = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("arst_mem_wvalid", {31'd0, mem_wvalid}, 32'd0);
      chk("arst_sb_count", {29'd0, sb_count}, 32'd0);
      chk("arst_sb_empty", {31'd0, sb_empty}, 32'd1);
      model_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      store(32'h400, 32'h0BAD0000, 4'hF, 1'b0);
      for (int k = 1; k <= 10; k++) store(32'h400 + 32'(4 * k), 32'h0BAD0000 + 32'(k), 4'(k), 1'b1);
      drain();

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         cycle(r < 4, r >= 4 && r < 7, 32'h200 + 32'(4 * $urandom_range(0, 7)), $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom);
      end
      drain();
      idle(1'b1);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipeline_mem_sb.md
# pipeline_mem_sb

Parametrised MEM-stage successor with a posted store buffer. Stores from the ALU are queued in a SB_DEPTH-entry FIFO and drained to data memory over a valid/ready write port, so the pipeline never waits on memory writes. Loads read memory combinationally and merge in bytes from pending stores in the same cycle. The block sits between the ALU stage and writeback, and reports buffer overflow and hazards through the existing 3-bit exception path.

## Interface
Parameters:
- ADDR_W, 32, byte address width; word address is ADDR_W-2 bits.
- SB_DEPTH, 4, store-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rt_value  in  32  store data, already lane-aligned.
- rd_value  in  ADDR_W  effective address from the ALU.
- wbyte_enable  in  4  byte enables for the store.
- memread_enable, memwrite_enable  in  1  load or store request.
- alu_memop_disable  in  1  ALU override; suppresses any memop.
- has_final_exception  in  1  an older exception is pending; suppresses stores.
- out_value  out  32  load data after merging.
- exception  out  3  codes from pipeline_mem_pkg.
- mem_wvalid, mem_wready  out/in  1  handshake for the write port.
- mem_waddr  out  ADDR_W-2  word address of the buffer head.
- mem_wdata  out  32  head data.
- mem_wbe  out  4  head byte enables.
- mem_raddr  out  ADDR_W-2  combinational read address, equal to rd_value[ADDR_W-1:2].
- mem_rdata  in  32  combinational read data.
- sb_empty  out  1  buffer drained; used by fences.
- sb_count  out  $clog2(SB_DEPTH)+1  current number of entries.

## Operation
- Derived requests:
  - ld = memread_enable & ~alu_memop_disable.
  - st = memwrite_enable & ~alu_memop_disable & ~has_final_exception.
- Store:
  - If st and count < SB_DEPTH, push {word address, rt_value, wbyte_enable} at the tail on the next edge. exception = EXC_NONE.
  - If st and count == SB_DEPTH, drop the store and set exception = EXC_SB_FULL. The pipeline flushes and retries.
  - Fullness is judged on the count before the edge. A drain in the same cycle does not make room.
- Drain:
  - mem_wvalid = ~sb_empty. The head fields are driven straight from storage.
  - On mem_wvalid & mem_wready, pop the head at the edge.
  - Head fields hold stable while mem_wvalid is high and mem_wready is low.
- Push and pop in the same cycle: count is unchanged; both pointers advance modulo SB_DEPTH.
- Load:
  - out_value = mem_rdata, with forwarding applied (see Configuration).
  - When ld is low, out_value is still driven, but its value is don't-care.
- A load and a store are never issued in the same cycle. If both are asserted, the store takes effect and the forwarding result is undefined.
- Reset while a drain is in flight: the buffer empties immediately and the pending write is lost. Software must fence before any controlled reset.

## Timing
- Reset values: count = 0, head and tail pointers = 0, entry valid bits = 0, sb_empty = 1, mem_wvalid = 0, sb_count = 0, exception = EXC_NONE.
- out_value is combinational, so a load completes in zero cycles.
- exception is combinational in the same cycle as the request.
- A pushed entry appears at the head, or becomes visible to forwarding, starting the cycle after the push edge.
- Minimum residency of an entry is 1 cycle.
- Drain throughput: one entry per cycle while mem_wready is held high.

## Configuration
- PIPELINE_MEM_SB_FWD_EN defined:
  - For each byte lane, out_value takes that byte from the youngest valid entry whose word address matches and whose be bit is set.
  - Lanes with no matching entry take mem_rdata.
- Not defined:
  - A load whose word address matches any valid entry sets exception = EXC_SB_HAZARD and out_value = mem_rdata.
  - The pipeline replays the load after sb_empty.

## Structure
- pipeline_mem_pkg holds:
  - localparams EXC_NONE = 3'd0, EXC_SB_FULL = 3'd5, EXC_SB_HAZARD = 3'd6.
  - typedef sb_entry_t {waddr, data, be}.
- Sub-module store_buffer: the FIFO, with storage, pointers, count, per-entry valid bits and a parallel address-compare/merge output.
- The top level adds request qualification, the exception mux and the forwarding select.

## Test plan
- Reset, then store addr 0x10, data 0xAABBCCDD, be 4'hF, with mem_wready = 0 → sb_count = 1, mem_wvalid = 1, mem_waddr = 0x4. Raise mem_wready → pop next edge, sb_empty = 1.
- Four stores with mem_wready = 0, then a fifth → fifth gets exception = 5, sb_count stays 4. Store with has_final_exception = 1 → no push, exception = 0.
- Full buffer with mem_wready = 1 and a store in the same cycle → EXC_SB_FULL, count drops to 3 next edge.
- FWD_EN: store 0x11223344 be 4'b0011 to addr 0x20, mem_rdata = 0xAAAAAAAA, load 0x20 → out_value = 0xAAAA3344. A younger store 0x55 be 4'b0001 → out_value = 0xAAAA3355.
- No FWD_EN: same load → exception = 6. Load to a non-matching address → exception = 0, out_value = mem_rdata.
- Assert rst mid-drain with 3 entries → mem_wvalid = 0 and sb_count = 0 asynchronously. Ten pushes and pops interleaved → FIFO order preserved across pointer wrap.
